// File: rtl/osd_mam_wb_burst_if.sv
// -----------------------------------------------------------------------------
// osd_mam_wb_burst_if
//
// Bridge from the MAM request/write/read streams to a Wishbone B3 master.
// Supports classic cycles and registered-feedback incrementing bursts
// (CTI 010 / 111, BTE linear), bus errors, and a per-beat ack timeout.
// After an error or timeout the MAM streams are drained so that osd_mam
// stays in step: leftover write words are accepted and dropped, and the
// missing read words are returned as zero.
//
// Handshakes: every stream uses strict valid/ready semantics. A transfer
// happens on a rising clk_i edge where both valid and ready are high. Once
// raised, valid holds (with stable payload) until that edge. Ready never
// depends combinationally on valid; here it is decoded from registered state.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_*                  request stream (rw, byte address, burst, beats)
//   write_*                write data stream (strobes used for single beats)
//   read_*                 read data stream
//   err_o                  one-cycle pulse when a transfer is aborted
//   cyc_o..cti_o, bte_o    Wishbone master outputs (registered)
//   dat_i, ack_i, err_i    Wishbone master inputs
//   dbg_state              current FSM state, for observation only
// -----------------------------------------------------------------------------
module osd_mam_wb_burst_if #(
    parameter int DATA_WIDTH = 32,   // 8, 16, 32 or 64
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_EN   = 1,
    parameter int TIMEOUT    = 1024  // 0 disables the timeout
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_burst,
    input  logic [13:0]             req_beats,

    input  logic                    write_valid,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    write_ready,

    output logic                    read_valid,
    output logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    read_ready,

    output logic                    err_o,

    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH/8-1:0] sel_o,
    output logic [2:0]              cti_o,
    output logic [1:0]              bte_o,
    input  logic                    ack_i,
    input  logic                    err_i,

    output logic [2:0]              dbg_state
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_W);

    // Timeout counter only needs to hold 0..TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_DATA = 3'd1;
    localparam logic [2:0] ST_WR_BUS  = 3'd2;
    localparam logic [2:0] ST_RD_BUS  = 3'd3;
    localparam logic [2:0] ST_RD_OUT  = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    logic [2:0]    state;
    logic [13:0]   remaining;  // beats still to complete, including the one on the bus
    logic          rw_q;       // 1: write transfer
    logic          burst_q;    // CTI burst in use for this transfer
    logic          single_q;   // transfer is exactly one beat
    logic [TW-1:0] tmo_cnt;

    logic [13:0] beats_eff;
    logic        tmo_hit;
    logic        bus_fail;

    // CTI for the beat about to be issued, given the beats left including it.
    function automatic logic [2:0] cti_for(input logic burst, input logic [13:0] rem);
        if (!burst)
            return 3'b000;
        else if (rem > 14'd1)
            return 3'b010;
        else
            return 3'b111;
    endfunction

    assign beats_eff = (req_beats == 14'd0) ? 14'd1 : req_beats;

    // The TIMEOUT-th waiting cycle counts as an error; err_i has priority
    // over ack_i when both arrive together.
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign bus_fail = err_i || tmo_hit;

    assign req_ready   = (state == ST_IDLE);
    assign write_ready = (state == ST_WR_DATA) ||
                         ((state == ST_DRAIN) && rw_q && (remaining > 14'd1));
    assign read_valid  = (state == ST_RD_OUT) ||
                         ((state == ST_DRAIN) && !rw_q);
    assign bte_o       = 2'b00;
    assign dbg_state   = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            remaining <= '0;
            rw_q      <= 1'b0;
            burst_q   <= 1'b0;
            single_q  <= 1'b0;
            tmo_cnt   <= '0;
            err_o     <= 1'b0;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            addr_o    <= '0;
            dat_o     <= '0;
            sel_o     <= '0;
            cti_o     <= 3'b000;
            read_data <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_o    <= req_addr;
                        remaining <= beats_eff;
                        rw_q      <= req_rw;
                        burst_q   <= req_burst && (BURST_EN != 0);
                        single_q  <= (beats_eff == 14'd1);
                        if (req_rw) begin
                            state <= ST_WR_DATA;
                        end else begin
                            // Reads go straight onto the bus.
                            state   <= ST_RD_BUS;
                            cyc_o   <= 1'b1;
                            stb_o   <= 1'b1;
                            we_o    <= 1'b0;
                            sel_o   <= '1;
                            cti_o   <= cti_for(req_burst && (BURST_EN != 0), beats_eff);
                            tmo_cnt <= '0;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (write_valid) begin
                        dat_o   <= write_data;
                        sel_o   <= single_q ? write_strb : '1;
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        we_o    <= 1'b1;
                        cti_o   <= cti_for(burst_q, remaining);
                        tmo_cnt <= '0;
                        state   <= ST_WR_BUS;
                    end
                end

                ST_WR_BUS, ST_RD_BUS: begin
                    if (bus_fail) begin
                        // Abort: the failed beat stays in 'remaining' so the
                        // drain covers it.
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        err_o <= 1'b1;
                        if (!rw_q)
                            read_data <= '0;
                        state <= ST_DRAIN;
                    end else if (ack_i) begin
                        remaining <= remaining - 14'd1;
                        addr_o    <= addr_o + ADDR_STEP;
                        stb_o     <= 1'b0;
                        we_o      <= 1'b0;
                        // A burst keeps the cycle open across wait states,
                        // up to and including its last ack.
                        cyc_o     <= burst_q && (remaining != 14'd1);
                        if (state == ST_RD_BUS) begin
                            read_data <= dat_i;
                            state     <= ST_RD_OUT;
                        end else if (remaining == 14'd1) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_WR_DATA;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_RD_OUT: begin
                    if (read_ready) begin
                        if (remaining == 14'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            cyc_o   <= 1'b1;
                            stb_o   <= 1'b1;
                            cti_o   <= cti_for(burst_q, remaining);
                            tmo_cnt <= '0;
                            state   <= ST_RD_BUS;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (rw_q) begin
                        // The failed beat's word was already taken; swallow
                        // the remaining-1 words osd_mam still wants to send.
                        if (remaining <= 14'd1) begin
                            state <= ST_IDLE;
                        end else if (write_valid) begin
                            remaining <= remaining - 14'd1;
                            if (remaining == 14'd2)
                                state <= ST_IDLE;
                        end
                    end else begin
                        // read_data was cleared on abort; return zeros.
                        if (read_ready) begin
                            remaining <= remaining - 14'd1;
                            if (remaining == 14'd1)
                                state <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_mam_wb_burst_if.sv
// -----------------------------------------------------------------------------
// Directed bench for osd_mam_wb_burst_if. Three instances share all inputs:
//   0: burst-capable, TIMEOUT=16
//   1: BURST_EN=0 (classic only), TIMEOUT=16
//   2: ADDR_WIDTH=16, burst-capable
// 'sel' picks the instance whose outputs the Wishbone slave and the checks
// look at; each phase starts with a reset so the others are irrelevant.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_osd_mam_wb_burst_if;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    logic        clk;
    logic        rst_ni;
    logic        req_valid, req_rw, req_burst;
    logic [31:0] req_addr;
    logic [13:0] req_beats;
    logic        write_valid;
    logic [31:0] write_data;
    logic [3:0]  write_strb;
    logic        read_ready;
    logic [31:0] dat_i;
    logic        ack_i, err_i;

    logic        req_ready_w   [3];
    logic        write_ready_w [3];
    logic        read_valid_w  [3];
    logic [31:0] read_data_w   [3];
    logic        err_w         [3];
    logic        cyc_w         [3];
    logic        stb_w         [3];
    logic        we_w          [3];
    logic [31:0] addr_w        [3];
    logic [31:0] dat_o_w       [3];
    logic [3:0]  sel_o_w       [3];
    logic [2:0]  cti_w         [3];
    logic [1:0]  bte_w         [3];
    logic [2:0]  state_w       [3];
    logic [15:0] addr16;

    int sel = 0;
    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- DUTs ----------------
    osd_mam_wb_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_EN(1), .TIMEOUT(16)) u_burst (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready_w[0]), .req_rw(req_rw),
        .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb),
        .write_ready(write_ready_w[0]),
        .read_valid(read_valid_w[0]), .read_data(read_data_w[0]), .read_ready(read_ready),
        .err_o(err_w[0]), .cyc_o(cyc_w[0]), .stb_o(stb_w[0]), .we_o(we_w[0]),
        .addr_o(addr_w[0]), .dat_o(dat_o_w[0]), .dat_i(dat_i), .sel_o(sel_o_w[0]),
        .cti_o(cti_w[0]), .bte_o(bte_w[0]), .ack_i(ack_i), .err_i(err_i),
        .dbg_state(state_w[0])
    );

    osd_mam_wb_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_EN(0), .TIMEOUT(16)) u_classic (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready_w[1]), .req_rw(req_rw),
        .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb),
        .write_ready(write_ready_w[1]),
        .read_valid(read_valid_w[1]), .read_data(read_data_w[1]), .read_ready(read_ready),
        .err_o(err_w[1]), .cyc_o(cyc_w[1]), .stb_o(stb_w[1]), .we_o(we_w[1]),
        .addr_o(addr_w[1]), .dat_o(dat_o_w[1]), .dat_i(dat_i), .sel_o(sel_o_w[1]),
        .cti_o(cti_w[1]), .bte_o(bte_w[1]), .ack_i(ack_i), .err_i(err_i),
        .dbg_state(state_w[1])
    );

    osd_mam_wb_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BURST_EN(1), .TIMEOUT(1024)) u_aw16 (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready_w[2]), .req_rw(req_rw),
        .req_addr(req_addr[15:0]), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb),
        .write_ready(write_ready_w[2]),
        .read_valid(read_valid_w[2]), .read_data(read_data_w[2]), .read_ready(read_ready),
        .err_o(err_w[2]), .cyc_o(cyc_w[2]), .stb_o(stb_w[2]), .we_o(we_w[2]),
        .addr_o(addr16), .dat_o(dat_o_w[2]), .dat_i(dat_i), .sel_o(sel_o_w[2]),
        .cti_o(cti_w[2]), .bte_o(bte_w[2]), .ack_i(ack_i), .err_i(err_i),
        .dbg_state(state_w[2])
    );

    assign addr_w[2] = {16'h0000, addr16};

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid   = 1'b0;
        req_rw      = 1'b0;
        req_burst   = 1'b0;
        req_addr    = '0;
        req_beats   = '0;
        write_valid = 1'b0;
        write_data  = '0;
        write_strb  = '0;
        read_ready  = 1'b0;
        dat_i       = '0;
        ack_i       = 1'b0;
        err_i       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic send_req(input logic rw, input logic [31:0] addr,
                            input logic burst, input logic [13:0] beats);
        req_rw    = rw;
        req_addr  = addr;
        req_burst = burst;
        req_beats = beats;
        req_valid = 1'b1;
        check("req_ready", 32'(req_ready_w[sel]), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_stb();
        for (int k = 0; k < 32; k++) begin
            if (stb_w[sel]) break;
            tick();
        end
        check("wait_stb", 32'(stb_w[sel]), 32'd1);
    endtask

    task automatic wait_wready();
        for (int k = 0; k < 32; k++) begin
            if (write_ready_w[sel]) break;
            tick();
        end
        check("wait_wready", 32'(write_ready_w[sel]), 32'd1);
    endtask

    // Read of n beats; the slave acks each strobe at once with 0x10+i.
    // bp_beat: index of the beat held back by 3 cycles of read_ready=0.
    task automatic run_read(input int n, input logic [31:0] base, input logic req_b,
                            input logic burst_exp, input logic [31:0] mask, input int bp_beat);
        logic [31:0] d;
        send_req(1'b0, base, req_b, 14'(n));
        check("rd_latency", 32'(stb_w[sel]), 32'd1);
        for (int i = 0; i < n; i++) begin
            wait_stb();
            check("rd_addr", addr_w[sel], (base + 32'(4 * i)) & mask);
            check("rd_cti", 32'(cti_w[sel]),
                  burst_exp ? ((i == n - 1) ? 32'd7 : 32'd2) : 32'd0);
            check("rd_cyc_on_stb", 32'(cyc_w[sel]), 32'd1);
            check("rd_we", 32'(we_w[sel]), 32'd0);
            check("rd_sel", 32'(sel_o_w[sel]), 32'hF);
            d = 32'h10 + 32'(i);
            exp_q.push_back(d);
            dat_i = d;
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            dat_i = '0;
            check("rd_valid", 32'(read_valid_w[sel]), 32'd1);
            check("rd_stb_low", 32'(stb_w[sel]), 32'd0);
            check("rd_cyc_between", 32'(cyc_w[sel]), 32'(burst_exp && (i < n - 1)));
            if (i == bp_beat) begin
                repeat (3) begin
                    tick();
                    check("bp_valid", 32'(read_valid_w[sel]), 32'd1);
                    check("bp_cyc", 32'(cyc_w[sel]), 32'(burst_exp && (i < n - 1)));
                end
            end
            if (exp_q.size() > 0)
                check("rd_data", read_data_w[sel], exp_q.pop_front());
            read_ready = 1'b1;
            tick();
            read_ready = 1'b0;
        end
        check("rd_idle", 32'(state_w[sel]), 32'(ST_IDLE));
        check("rd_valid_done", 32'(read_valid_w[sel]), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int stb_cnt;
        int err_cnt;
        int acc_cnt;
        int busy_cnt;
        logic err_seen;

        // Reset values, sampled while reset is held.
        sel = 0;
        clear_inputs();
        rst_ni = 1'b0;
        tick();
        check("rst_req_ready", 32'(req_ready_w[0]), 32'd1);
        check("rst_cyc", 32'(cyc_w[0]), 32'd0);
        check("rst_stb", 32'(stb_w[0]), 32'd0);
        check("rst_we", 32'(we_w[0]), 32'd0);
        check("rst_read_valid", 32'(read_valid_w[0]), 32'd0);
        check("rst_write_ready", 32'(write_ready_w[0]), 32'd0);
        check("rst_err", 32'(err_w[0]), 32'd0);
        check("rst_addr", addr_w[0], 32'd0);
        check("rst_dat_o", dat_o_w[0], 32'd0);
        check("rst_read_data", read_data_w[0], 32'd0);
        check("rst_cti", 32'(cti_w[0]), 32'd0);
        check("rst_bte", 32'(bte_w[0]), 32'd0);

        // 1. Single write; err_i while in WR_DATA must be ignored.
        do_reset();
        send_req(1'b1, 32'h100, 1'b0, 14'd1);
        check("wr_ready", 32'(write_ready_w[0]), 32'd1);
        check("wr_no_cyc", 32'(cyc_w[0]), 32'd0);
        write_data  = 32'hDEADBEEF;
        write_strb  = 4'b0011;
        write_valid = 1'b1;
        err_i       = 1'b1;
        tick();
        write_valid = 1'b0;
        err_i       = 1'b0;
        check("wr_err_ignored", 32'(err_w[0]), 32'd0);
        check("wr_stb", 32'(stb_w[0]), 32'd1);
        check("wr_we", 32'(we_w[0]), 32'd1);
        check("wr_sel", 32'(sel_o_w[0]), 32'h3);
        check("wr_cti", 32'(cti_w[0]), 32'd0);
        check("wr_addr", addr_w[0], 32'h100);
        check("wr_dat", dat_o_w[0], 32'hDEADBEEF);
        tick();
        check("wr_stb_wait", 32'(stb_w[0]), 32'd1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check("wr_idle", 32'(state_w[0]), 32'(ST_IDLE));
        check("wr_cyc_off", 32'(cyc_w[0]), 32'd0);
        check("wr_we_off", 32'(we_w[0]), 32'd0);

        // 2. 4-beat burst read with backpressure on beat 2.
        do_reset();
        run_read(4, 32'h2000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1);

        // 3. Same burst on the classic-only instance.
        sel = 1;
        do_reset();
        run_read(4, 32'h2000, 1'b1, 1'b0, 32'hFFFF_FFFF, 1);

        // 4. 8-beat burst write, ack+err together on beat 3 (err wins).
        sel = 0;
        do_reset();
        send_req(1'b1, 32'h3000, 1'b1, 14'd8);
        for (int i = 0; i < 3; i++) begin
            wait_wready();
            write_data  = 32'hA0 + 32'(i);
            write_strb  = 4'b0001;
            write_valid = 1'b1;
            tick();
            write_valid = 1'b0;
            check("bw_stb", 32'(stb_w[0]), 32'd1);
            check("bw_addr", addr_w[0], 32'h3000 + 32'(4 * i));
            check("bw_cti", 32'(cti_w[0]), 32'd2);
            check("bw_sel", 32'(sel_o_w[0]), 32'hF);
            check("bw_dat", dat_o_w[0], 32'hA0 + 32'(i));
            ack_i = 1'b1;
            if (i == 2) err_i = 1'b1;
            tick();
            ack_i = 1'b0;
            err_i = 1'b0;
            if (i < 2)
                check("bw_cyc_held", 32'(cyc_w[0]), 32'd1);
        end
        check("bw_err_pulse", 32'(err_w[0]), 32'd1);
        check("bw_cyc_drop", 32'(cyc_w[0]), 32'd0);
        check("bw_drain", 32'(state_w[0]), 32'(ST_DRAIN));
        write_valid = 1'b1;
        acc_cnt  = 0;
        busy_cnt = 0;
        err_cnt  = 0;
        for (int k = 0; k < 30; k++) begin
            if (state_w[0] == ST_IDLE) break;
            if (write_ready_w[0]) acc_cnt++;
            if (cyc_w[0] || stb_w[0]) busy_cnt++;
            if (err_w[0]) err_cnt++;
            tick();
        end
        write_valid = 1'b0;
        check("bw_drain_words", 32'(acc_cnt), 32'd5);
        check("bw_no_bus", 32'(busy_cnt), 32'd0);
        check("bw_err_once", 32'(err_cnt), 32'd1);
        check("bw_idle", 32'(state_w[0]), 32'(ST_IDLE));

        // 5. Read timeout with a silent slave.
        do_reset();
        send_req(1'b0, 32'h4000, 1'b0, 14'd1);
        stb_cnt  = 0;
        err_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (err_w[0]) begin
                err_seen = 1'b1;
                break;
            end
            if (stb_w[0]) stb_cnt++;
            tick();
        end
        check("tmo_err", 32'(err_seen), 32'd1);
        check("tmo_stb_cycles", 32'(stb_cnt), 32'd16);
        check("tmo_cyc", 32'(cyc_w[0]), 32'd0);
        check("tmo_valid", 32'(read_valid_w[0]), 32'd1);
        check("tmo_data", read_data_w[0], 32'd0);
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        check("tmo_idle", 32'(state_w[0]), 32'(ST_IDLE));
        check("tmo_valid_off", 32'(read_valid_w[0]), 32'd0);

        // 6. 16-bit address wrap, then asynchronous reset mid-burst.
        sel = 2;
        do_reset();
        run_read(2, 32'hFFFC, 1'b1, 1'b1, 32'h0000_FFFF, -1);
        send_req(1'b0, 32'h0100, 1'b1, 14'd4);
        dat_i = 32'h55;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        check("mid_stb", 32'(stb_w[2]), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_cyc", 32'(cyc_w[2]), 32'd0);
        check("arst_stb", 32'(stb_w[2]), 32'd0);
        check("arst_addr", addr_w[2], 32'd0);
        check("arst_cti", 32'(cti_w[2]), 32'd0);
        check("arst_read_data", read_data_w[2], 32'd0);
        check("arst_req_ready", 32'(req_ready_w[2]), 32'd1);
        check("arst_err", 32'(err_w[2]), 32'd0);
        clear_inputs();
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_rst_err", 32'(err_w[2]), 32'd0);
        run_read(1, 32'h0040, 1'b1, 1'b1, 32'h0000_FFFF, -1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
